// File: rtl/dpram_param.sv
// dpram_param: parametrised true dual-port RAM, two independent ports on one clock.
//
// Per-port byte-lane writes, READ_LATENCY (1 or 2) registered reads with a
// one-cycle valid pulse, and defined same-address cross-port behaviour:
//   both write  -> lanes enabled on both ports take port A's data
//   write/read  -> read returns old data (READ_MODE=0) or merged new data (READ_MODE=1)
//   both read   -> identical data, no collision
// An optional zero-fill sweep runs after reset before accesses are accepted.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   enable/write/byte_en/address/data_in_port_{a,b}   access request per port
//   data_out_port_{a,b}, valid_port_{a,b}             read data and one-cycle strobe
//   collision                        pulse one cycle after a same-address conflict
//   init_done                        high once the RAM accepts accesses
//
// FSM states
//   state    | meaning
//   ST_INIT  | after reset; zero-fill sweep (or single pass-through edge), ports ignored
//   ST_READY | normal operation, ports live

module dpram_param #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int READ_LATENCY   = 1,
    parameter int READ_MODE      = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable_port_a,
    input  logic                    write_port_a,
    input  logic [DATA_WIDTH/8-1:0] byte_en_port_a,
    input  logic [ADDR_WIDTH-1:0]   address_port_a,
    input  logic [DATA_WIDTH-1:0]   data_in_port_a,
    output logic [DATA_WIDTH-1:0]   data_out_port_a,
    output logic                    valid_port_a,
    input  logic                    enable_port_b,
    input  logic                    write_port_b,
    input  logic [DATA_WIDTH/8-1:0] byte_en_port_b,
    input  logic [ADDR_WIDTH-1:0]   address_port_b,
    input  logic [DATA_WIDTH-1:0]   data_in_port_b,
    output logic [DATA_WIDTH-1:0]   data_out_port_b,
    output logic                    valid_port_b,
    output logic                    collision,
    output logic                    init_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   count, count_nxt;
    logic                    clr_we;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    port_live;
    logic                    wr_a, wr_b, rd_a, rd_b, same_addr;
    logic [DATA_WIDTH-1:0]   old_a, old_b, new_a, new_b, rdata_a, rdata_b;

    // ---------------- sequencing FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INIT;
            count     <= '0;
            collision <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            // same-address conflict involving at least one write
            collision <= same_addr && (wr_a || wr_b);
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        clr_we    = 1'b0;
        case (state)
            ST_INIT: begin
                if (CLEAR_ON_RESET != 0) begin
                    clr_we    = 1'b1;
                    count_nxt = count + 1'b1;
                    if (count == {ADDR_WIDTH{1'b1}}) begin
                        state_nxt = ST_READY;
                    end
                end else begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                state_nxt = ST_READY;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    assign init_done = (state == ST_READY);

    // ---------------- port qualification ----------------
    assign port_live = (state == ST_READY) && !reset;
    assign wr_a      = port_live && enable_port_a && write_port_a;
    assign wr_b      = port_live && enable_port_b && write_port_b;
    assign rd_a      = port_live && enable_port_a && !write_port_a;
    assign rd_b      = port_live && enable_port_b && !write_port_b;
    assign same_addr = port_live && enable_port_a && enable_port_b
                       && (address_port_a == address_port_b);

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (clr_we && !reset) begin
            mem[count] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_a && byte_en_port_a[i]) begin
                    mem[address_port_a][i*8 +: 8] <= data_in_port_a[i*8 +: 8];
                end
                // port A owns any lane both ports write at the same address
                if (wr_b && byte_en_port_b[i]
                    && !(same_addr && wr_a && byte_en_port_a[i])) begin
                    mem[address_port_b][i*8 +: 8] <= data_in_port_b[i*8 +: 8];
                end
            end
        end
    end

    // ---------------- read data selection ----------------
    assign old_a = mem[address_port_a];
    assign old_b = mem[address_port_b];

    // write-through view: overlay the other port's same-cycle write lanes
    always_comb begin
        new_a = old_a;
        new_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (same_addr && wr_b && byte_en_port_b[i]) begin
                new_a[i*8 +: 8] = data_in_port_b[i*8 +: 8];
            end
            if (same_addr && wr_a && byte_en_port_a[i]) begin
                new_b[i*8 +: 8] = data_in_port_a[i*8 +: 8];
            end
        end
    end

    assign rdata_a = (READ_MODE != 0) ? new_a : old_a;
    assign rdata_b = (READ_MODE != 0) ? new_b : old_b;

    // ---------------- read pipeline ----------------
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  pv_a, pv_b;
            logic [DATA_WIDTH-1:0] pd_a, pd_b;

            always_ff @(posedge clk) begin
                if (reset) begin
                    pv_a            <= 1'b0;
                    pv_b            <= 1'b0;
                    pd_a            <= '0;
                    pd_b            <= '0;
                    valid_port_a    <= 1'b0;
                    valid_port_b    <= 1'b0;
                    data_out_port_a <= '0;
                    data_out_port_b <= '0;
                end else begin
                    pv_a         <= rd_a;
                    pv_b         <= rd_b;
                    valid_port_a <= pv_a;
                    valid_port_b <= pv_b;
                    if (rd_a) pd_a <= rdata_a;
                    if (rd_b) pd_b <= rdata_b;
                    if (pv_a) data_out_port_a <= pd_a;
                    if (pv_b) data_out_port_b <= pd_b;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_port_a    <= 1'b0;
                    valid_port_b    <= 1'b0;
                    data_out_port_a <= '0;
                    data_out_port_b <= '0;
                end else begin
                    valid_port_a <= rd_a;
                    valid_port_b <= rd_b;
                    if (rd_a) data_out_port_a <= rdata_a;
                    if (rd_b) data_out_port_b <= rdata_b;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_dpram_param.sv
// Bench for dpram_param: two instances share one stimulus stream,
// u1 = READ_LATENCY 1 / READ_MODE 0 (old data), u2 = READ_LATENCY 2 / READ_MODE 1 (new data).
// A reference memory model produces expected read data, queued with the edge at
// which each instance must present it.

module tb_dpram_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, we_a, en_b, we_b;
    logic [3:0]  be_a, be_b, ad_a, ad_b;
    logic [31:0] di_a, di_b;

    logic [31:0] do1_a, do1_b, do2_a, do2_b;
    logic        v1_a, v1_b, v2_a, v2_b, col1, col2, idn1, idn2;

    always #5 clk = ~clk;

    dpram_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .READ_MODE(0),
                  .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .reset(rst),
        .enable_port_a(en_a), .write_port_a(we_a), .byte_en_port_a(be_a),
        .address_port_a(ad_a), .data_in_port_a(di_a),
        .data_out_port_a(do1_a), .valid_port_a(v1_a),
        .enable_port_b(en_b), .write_port_b(we_b), .byte_en_port_b(be_b),
        .address_port_b(ad_b), .data_in_port_b(di_b),
        .data_out_port_b(do1_b), .valid_port_b(v1_b),
        .collision(col1), .init_done(idn1));

    dpram_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .READ_MODE(1),
                  .CLEAR_ON_RESET(1)) u2 (
        .clk(clk), .reset(rst),
        .enable_port_a(en_a), .write_port_a(we_a), .byte_en_port_a(be_a),
        .address_port_a(ad_a), .data_in_port_a(di_a),
        .data_out_port_a(do2_a), .valid_port_a(v2_a),
        .enable_port_b(en_b), .write_port_b(we_b), .byte_en_port_b(be_b),
        .address_port_b(ad_b), .data_in_port_b(di_b),
        .data_out_port_b(do2_b), .valid_port_b(v2_b),
        .collision(col2), .init_done(idn2));

    typedef struct {
        int          due;
        logic [31:0] d;
    } rd_t;

    // queue index: 0 = u1 port A, 1 = u1 port B, 2 = u2 port A, 3 = u2 port B
    rd_t         q [4][$];
    logic [31:0] exp_do [4];
    logic [31:0] model [16];
    logic        exp_ready;
    logic        exp_col;
    int          sweep;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle();
        en_a = 0; we_a = 0; be_a = 4'h0; ad_a = 4'h0; di_a = '0;
        en_b = 0; we_b = 0; be_b = 4'h0; ad_b = 4'h0; di_b = '0;
    endtask

    task automatic pa(input logic we, input logic [3:0] be, input logic [3:0] ad,
                      input logic [31:0] d);
        en_a = 1; we_a = we; be_a = be; ad_a = ad; di_a = d;
    endtask

    task automatic pb(input logic we, input logic [3:0] be, input logic [3:0] ad,
                      input logic [31:0] d);
        en_b = 1; we_b = we; be_b = be; ad_b = ad; di_b = d;
    endtask

    // Apply the current inputs for one clock edge, update the model, then check all outputs.
    task automatic tick();
        int          e;
        logic        same;
        logic [31:0] old, nw, obs_d;
        logic        obs_v, exp_v;
        e = cyc + 1;
        if (rst) begin
            for (int p = 0; p < 4; p++) begin
                q[p].delete();
                exp_do[p] = '0;
            end
            exp_ready = 0;
            sweep     = 0;
            exp_col   = 0;
        end else if (!exp_ready) begin
            model[sweep] = '0;
            sweep++;
            if (sweep == 16) exp_ready = 1;
            exp_col = 0;
        end else begin
            same    = en_a && en_b && (ad_a == ad_b);
            exp_col = same && (we_a || we_b);
            if (en_a && !we_a) begin
                old = model[ad_a];
                nw  = (same && we_b) ? merge(old, be_b, di_b) : old;
                q[0].push_back('{due: e, d: old});
                q[2].push_back('{due: e + 1, d: nw});
            end
            if (en_b && !we_b) begin
                old = model[ad_b];
                nw  = (same && we_a) ? merge(old, be_a, di_a) : old;
                q[1].push_back('{due: e, d: old});
                q[3].push_back('{due: e + 1, d: nw});
            end
            // B first so that A wins any shared lane at a shared address
            if (en_b && we_b) model[ad_b] = merge(model[ad_b], be_b, di_b);
            if (en_a && we_a) model[ad_a] = merge(model[ad_a], be_a, di_a);
        end

        @(posedge clk);
        cyc++;
        #1;

        chk("init_done u1", {31'b0, idn1}, {31'b0, exp_ready});
        chk("init_done u2", {31'b0, idn2}, {31'b0, exp_ready});
        chk("collision u1", {31'b0, col1}, {31'b0, exp_col});
        chk("collision u2", {31'b0, col2}, {31'b0, exp_col});
        for (int p = 0; p < 4; p++) begin
            case (p)
                0:       begin obs_d = do1_a; obs_v = v1_a; end
                1:       begin obs_d = do1_b; obs_v = v1_b; end
                2:       begin obs_d = do2_a; obs_v = v2_a; end
                default: begin obs_d = do2_b; obs_v = v2_b; end
            endcase
            exp_v = (q[p].size() > 0) && (q[p][0].due == cyc);
            if (exp_v) begin
                exp_do[p] = q[p][0].d;
                void'(q[p].pop_front());
            end
            chk($sformatf("valid q%0d", p), {31'b0, obs_v}, {31'b0, exp_v});
            chk($sformatf("data_out q%0d", p), obs_d, exp_do[p]);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        exp_ready = 0;
        exp_col   = 0;
        sweep     = 0;
        for (int p = 0; p < 4; p++) exp_do[p] = '0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        idle();

        // reset, then zero-fill sweep: init_done low for 15 edges, high after the 16th
        rst = 1;
        ticks(2);
        rst = 0;
        ticks(16);

        // every word reads back zero, both ports
        for (int i = 0; i < 16; i++) begin
            idle();
            pa(0, 4'h0, i[3:0], '0);
            pb(0, 4'h0, 4'(15 - i), '0);
            tick();
        end
        idle(); ticks(3);

        // write then read on the other port next cycle
        pa(1, 4'hF, 4'd5, 32'hDEADBEEF); tick();
        idle(); pb(0, 4'h0, 4'd5, '0);   tick();
        idle(); ticks(3);

        // byte-lane merge
        pa(1, 4'hF, 4'd2, 32'h11223344);    tick();
        pa(1, 4'b0101, 4'd2, 32'hAABBCCDD); tick();
        pa(0, 4'h0, 4'd2, '0);              tick();
        idle(); ticks(3);

        // both ports write the same word
        pa(1, 4'hF, 4'd3, 32'hAAAAAAAA); pb(1, 4'hF, 4'd3, 32'h55555555); tick();
        idle(); pa(0, 4'h0, 4'd3, '0); tick();
        idle(); ticks(2);
        pa(1, 4'b0011, 4'd3, 32'hAAAAAAAA); pb(1, 4'b1100, 4'd3, 32'h55555555); tick();
        idle(); pb(0, 4'h0, 4'd3, '0); tick();
        idle(); ticks(3);

        // write on one port, read the same word on the other
        pa(1, 4'hF, 4'd7, 32'h1); tick();
        pa(1, 4'hF, 4'd7, 32'h2); pb(0, 4'h0, 4'd7, '0); tick();
        idle(); ticks(3);
        pb(1, 4'b1010, 4'd7, 32'hFF00FF00); pa(0, 4'h0, 4'd7, '0); tick();
        idle(); ticks(3);

        // both read the same word: identical data, no collision
        pa(0, 4'h0, 4'd7, '0); pb(0, 4'h0, 4'd7, '0); tick();
        idle(); ticks(3);

        // write with no byte lanes enabled changes nothing
        pa(1, 4'h0, 4'd5, 32'h12345678); tick();
        idle(); pa(0, 4'h0, 4'd5, '0); tick();
        idle(); ticks(3);

        // mixed back-to-back traffic on a small address window
        for (int i = 0; i < 200; i++) begin
            idle();
            if ($urandom_range(0, 3) != 0)
                pa(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 3) != 0)
                pb(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 3)), $urandom);
            tick();
        end
        idle(); ticks(3);

        // reset while a latency-2 read is still in flight
        pa(0, 4'h0, 4'd5, '0); tick();
        idle(); rst = 1; tick();
        rst = 0; ticks(8);
        // reset again mid-sweep, then a full sweep
        rst = 1; tick();
        rst = 0; ticks(16);
        pa(0, 4'h0, 4'd2, '0); pb(0, 4'h0, 4'd5, '0); tick();
        idle(); ticks(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
